// File: rtl/regfile_writeback.sv
// Register-file writeback stage: scoreboard of pending writes, load-result FIFO,
// and a single registered write port shared by the ALU (priority) and the FIFO head.
module regfile_writeback #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,
  input  logic [4:0]  rs1_q,
  input  logic [4:0]  rs2_q,
  output logic        rs1_busy,
  output logic        rs2_busy,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mem_valid,
  input  logic [4:0]  mem_rd,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic        reg_write
);
  localparam int DATA_W = 32;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;

  logic [31:0]       busy;
  logic [31:0]       busy_next;
  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic              push, pop, issue_set;
  logic              vld_p0;
  logic [4:0]        rd_p0;
  logic [DATA_W-1:0] data_p0;

  assign issue_ready = !busy[issue_rd];
  assign rs1_busy    = busy[rs1_q];
  assign rs2_busy    = busy[rs2_q];
  assign mem_ready   = (count < CW'(FIFO_DEPTH));

  // Loads to x0 are accepted but dropped, so the FIFO only ever holds real writes.
  assign push      = mem_valid && mem_ready && (mem_rd != 5'd0);
  assign pop       = !alu_valid && (count != '0);
  assign issue_set = issue_valid && issue_ready && (issue_rd != 5'd0);

  // Stage p0: pick the commit source; an ALU result to x0 still owns the slot.
  always_comb begin
    vld_p0  = 1'b0;
    rd_p0   = alu_rd;
    data_p0 = alu_data;
    if (alu_valid) begin
      vld_p0 = (alu_rd != 5'd0);
    end else if (pop) begin
      vld_p0  = 1'b1;
      rd_p0   = fifo_rd[rd_ptr];
      data_p0 = fifo_data[rd_ptr];
    end
  end

  // Clear first so a same-cycle issue to the committing register wins.
  always_comb begin
    busy_next = busy;
    if (vld_p0)    busy_next[rd_p0]    = 1'b0;
    if (issue_set) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= mem_rd;
      fifo_data[wr_ptr] <= mem_data;
    end
  end

  // Stage p1: registered write port and control state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      reg_write  <= 1'b0;
      rd         <= '0;
      write_data <= '0;
    end else begin
      busy      <= busy_next;
      reg_write <= vld_p0;
      if (vld_p0) begin
        rd         <= rd_p0;
        write_data <= data_p0;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
